// File: rtl/arm7_shifter_stage_pkg.sv
// Shared types and shift helpers for the ARM7 shifter operand stage.
// Each shift helper returns {carry, result}. The carry is the last bit shifted out.
package arm7_shifter_stage_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shf_type_e;

    typedef enum logic {
        SHS_IDLE     = 1'b0,
        SHS_REG_WAIT = 1'b1
    } shs_state_e;

    typedef struct packed {
        logic        carry;
        logic [31:0] b;
    } shf_res_t;

    // The shift amount n may be 0..32.
    // A guard bit below or above the word captures the bit shifted out last.
    function automatic shf_res_t sh_lsl(input logic [31:0] op, input logic [5:0] n);
        logic [32:0] t;
        t = {1'b0, op} << n;
        return shf_res_t'(t);
    endfunction

    function automatic shf_res_t sh_lsr(input logic [31:0] op, input logic [5:0] n);
        logic [32:0] t;
        t = {op, 1'b0} >> n;
        return '{carry: t[0], b: t[32:1]};
    endfunction

    function automatic shf_res_t sh_asr(input logic [31:0] op, input logic [5:0] n);
        logic [32:0] t;
        t = $signed({op, 1'b0}) >>> n;
        return '{carry: t[0], b: t[32:1]};
    endfunction

    function automatic shf_res_t sh_ror(input logic [31:0] op, input logic [4:0] r);
        logic [31:0] t;
        t = (r == 5'd0) ? op : ((op >> r) | (op << (6'd32 - {1'b0, r})));
        return '{carry: t[31], b: t};
    endfunction

endpackage

// File: rtl/arm7_shifter_stage_shift_core.sv
// Combinational ARM7 shifter.
// Covers immediate rotate, immediate-amount shifts and register-amount shifts, with carry-out.
module arm7_shift_core
    import arm7_shifter_stage_pkg::*;
#(
    parameter int unsigned AMT_W = 8
) (
    input  logic [31:0]      op,
    input  logic [1:0]       shf_type,
    input  logic [AMT_W-1:0] amount,
    input  logic             imm_mode,
    input  logic             reg_mode,
    input  logic             c_in,
    output logic [31:0]      b,
    output logic             carry
);

    shf_res_t   res;
    logic [4:0] n5;

    always_comb begin
        res = '{carry: c_in, b: op};
        n5  = amount[4:0];
        if (imm_mode) begin
            res = sh_ror({24'h0, op[7:0]}, {op[11:8], 1'b0});
            if (op[11:8] == 4'd0) res.carry = c_in;
        end else if (reg_mode) begin
            if (amount != '0) begin
                unique case (shf_type_e'(shf_type))
                    SH_LSL: res = (amount > AMT_W'(32)) ? '0 : sh_lsl(op, amount[5:0]);
                    SH_LSR: res = (amount > AMT_W'(32)) ? '0 : sh_lsr(op, amount[5:0]);
                    SH_ASR: res = sh_asr(op, (amount >= AMT_W'(32)) ? 6'd32 : amount[5:0]);
                    SH_ROR: begin
                        if (n5 == 5'd0) res = '{carry: op[31], b: op};
                        else            res = sh_ror(op, n5);
                    end
                    default: ;
                endcase
            end
        end else begin
            // An immediate amount of 0 encodes LSR #32, ASR #32 or RRX.
            unique case (shf_type_e'(shf_type))
                SH_LSL: if (n5 != 5'd0) res = sh_lsl(op, {1'b0, n5});
                SH_LSR: res = sh_lsr(op, (n5 == 5'd0) ? 6'd32 : {1'b0, n5});
                SH_ASR: res = sh_asr(op, (n5 == 5'd0) ? 6'd32 : {1'b0, n5});
                SH_ROR: begin
                    if (n5 == 5'd0) res = '{carry: op[0], b: {c_in, op[31:1]}};
                    else            res = sh_ror(op, n5);
                end
                default: ;
            endcase
        end
    end

    assign b     = res.b;
    assign carry = res.carry;

endmodule

// File: rtl/arm7_shifter_stage.sv
// Registered shifter-operand stage ahead of the ALU, with a valid/ready handshake.
// Define ARM7_REGSHIFT_EXTRA_CYCLE_EN to give register-amount shifts a second cycle (REG_WAIT).
module arm7_shifter_stage
    import arm7_shifter_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned AMT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [DATA_W-1:0] Shf_Operand,
    input  logic              Shf_Imm_Mode,
    input  logic              Shf_Reg_Mode,
    input  logic [1:0]        Shf_Type,
    input  logic [4:0]        Shf_Amt_Imm,
    input  logic [DATA_W-1:0] Shf_Rs,
    input  logic [DATA_W-1:0] Shf_A,
    input  logic [4:0]        Shf_Cntrl,
    input  logic              Shf_C_In,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [DATA_W-1:0] Alu_A,
    output logic [DATA_W-1:0] Alu_B,
    output logic              Alu_C,
    output logic [4:0]        Alu_Cntrl,
    output logic              Shf_Carry
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic              alu_c_q, alu_c_d, shf_carry_q, shf_carry_d;
    logic [4:0]        alu_cntrl_q, alu_cntrl_d;

    logic              out_free, accept, load;
    logic [DATA_W-1:0] core_op, core_a, core_b;
    logic [1:0]        core_type;
    logic [AMT_W-1:0]  core_amt, live_amt;
    logic              core_imm, core_reg, core_c_in, core_carry;
    logic [4:0]        core_cntrl;
    logic              unused_rs_hi;

    assign unused_rs_hi = ^Shf_Rs[DATA_W-1:AMT_W];
    assign live_amt     = Shf_Reg_Mode ? Shf_Rs[AMT_W-1:0] : AMT_W'(Shf_Amt_Imm);
    assign out_free     = ~out_valid_q | Out_Ready;
    assign accept       = In_Valid & In_Ready;

`ifdef ARM7_REGSHIFT_EXTRA_CYCLE_EN
    shs_state_e        state_q, state_d;
    logic [DATA_W-1:0] lat_op_q, lat_op_d, lat_a_q, lat_a_d;
    logic [1:0]        lat_type_q, lat_type_d;
    logic [AMT_W-1:0]  lat_amt_q, lat_amt_d;
    logic              lat_c_in_q, lat_c_in_d;
    logic [4:0]        lat_cntrl_q, lat_cntrl_d;

    assign In_Ready = (state_q == SHS_IDLE) & out_free;

    always_comb begin
        state_d     = state_q;
        lat_op_d    = lat_op_q;
        lat_a_d     = lat_a_q;
        lat_type_d  = lat_type_q;
        lat_amt_d   = lat_amt_q;
        lat_c_in_d  = lat_c_in_q;
        lat_cntrl_d = lat_cntrl_q;
        load        = 1'b0;
        core_op     = Shf_Operand;
        core_a      = Shf_A;
        core_type   = Shf_Type;
        core_amt    = live_amt;
        core_imm    = Shf_Imm_Mode;
        core_reg    = Shf_Reg_Mode;
        core_c_in   = Shf_C_In;
        core_cntrl  = Shf_Cntrl;
        unique case (state_q)
            SHS_IDLE: begin
                // Immediate mode takes priority, so only true register shifts wait.
                if (accept && Shf_Reg_Mode && !Shf_Imm_Mode) begin
                    lat_op_d    = Shf_Operand;
                    lat_a_d     = Shf_A;
                    lat_type_d  = Shf_Type;
                    lat_amt_d   = live_amt;
                    lat_c_in_d  = Shf_C_In;
                    lat_cntrl_d = Shf_Cntrl;
                    state_d     = SHS_REG_WAIT;
                end else if (accept) begin
                    load = 1'b1;
                end
            end
            SHS_REG_WAIT: begin
                core_op    = lat_op_q;
                core_a     = lat_a_q;
                core_type  = lat_type_q;
                core_amt   = lat_amt_q;
                core_imm   = 1'b0;
                core_reg   = 1'b1;
                core_c_in  = lat_c_in_q;
                core_cntrl = lat_cntrl_q;
                if (out_free) begin
                    load    = 1'b1;
                    state_d = SHS_IDLE;
                end
            end
            default: state_d = SHS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SHS_IDLE;
            lat_op_q    <= '0;
            lat_a_q     <= '0;
            lat_type_q  <= '0;
            lat_amt_q   <= '0;
            lat_c_in_q  <= 1'b0;
            lat_cntrl_q <= '0;
        end else begin
            state_q     <= state_d;
            lat_op_q    <= lat_op_d;
            lat_a_q     <= lat_a_d;
            lat_type_q  <= lat_type_d;
            lat_amt_q   <= lat_amt_d;
            lat_c_in_q  <= lat_c_in_d;
            lat_cntrl_q <= lat_cntrl_d;
        end
    end
`else
    assign In_Ready = out_free;

    always_comb begin
        load       = accept;
        core_op    = Shf_Operand;
        core_a     = Shf_A;
        core_type  = Shf_Type;
        core_amt   = live_amt;
        core_imm   = Shf_Imm_Mode;
        core_reg   = Shf_Reg_Mode;
        core_c_in  = Shf_C_In;
        core_cntrl = Shf_Cntrl;
    end
`endif

    arm7_shift_core #(.AMT_W(AMT_W)) u_core (
        .op       (core_op),
        .shf_type (core_type),
        .amount   (core_amt),
        .imm_mode (core_imm),
        .reg_mode (core_reg),
        .c_in     (core_c_in),
        .b        (core_b),
        .carry    (core_carry)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_c_d     = alu_c_q;
        alu_cntrl_d = alu_cntrl_q;
        shf_carry_d = shf_carry_q;
        if (load) begin
            out_valid_d = 1'b1;
            alu_a_d     = core_a;
            alu_b_d     = core_b;
            alu_c_d     = core_c_in;
            alu_cntrl_d = core_cntrl;
            shf_carry_d = core_carry;
        end else if (Out_Ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_c_q     <= 1'b0;
            alu_cntrl_q <= '0;
            shf_carry_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_c_q     <= alu_c_d;
            alu_cntrl_q <= alu_cntrl_d;
            shf_carry_q <= shf_carry_d;
        end
    end

    assign Out_Valid = out_valid_q;
    assign Alu_A     = alu_a_q;
    assign Alu_B     = alu_b_q;
    assign Alu_C     = alu_c_q;
    assign Alu_Cntrl = alu_cntrl_q;
    assign Shf_Carry = shf_carry_q;

endmodule

// File: tb/tb_arm7_shifter_stage.sv
// Directed-vector bench for arm7_shifter_stage.
// Honours ARM7_REGSHIFT_EXTRA_CYCLE_EN for the expected register-shift latency.
module tb_arm7_shifter_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        In_Valid, In_Ready;
    logic [31:0] Shf_Operand, Shf_Rs, Shf_A;
    logic        Shf_Imm_Mode, Shf_Reg_Mode, Shf_C_In;
    logic [1:0]  Shf_Type;
    logic [4:0]  Shf_Amt_Imm, Shf_Cntrl;
    logic        Out_Valid, Out_Ready;
    logic [31:0] Alu_A, Alu_B;
    logic        Alu_C, Shf_Carry;
    logic [4:0]  Alu_Cntrl;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arm7_shifter_stage #(.DATA_W(32), .AMT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .In_Valid     (In_Valid),
        .In_Ready     (In_Ready),
        .Shf_Operand  (Shf_Operand),
        .Shf_Imm_Mode (Shf_Imm_Mode),
        .Shf_Reg_Mode (Shf_Reg_Mode),
        .Shf_Type     (Shf_Type),
        .Shf_Amt_Imm  (Shf_Amt_Imm),
        .Shf_Rs       (Shf_Rs),
        .Shf_A        (Shf_A),
        .Shf_Cntrl    (Shf_Cntrl),
        .Shf_C_In     (Shf_C_In),
        .Out_Valid    (Out_Valid),
        .Out_Ready    (Out_Ready),
        .Alu_A        (Alu_A),
        .Alu_B        (Alu_B),
        .Alu_C        (Alu_C),
        .Alu_Cntrl    (Alu_Cntrl),
        .Shf_Carry    (Shf_Carry)
    );

    typedef struct packed {
        logic        imm;
        logic        rgm;
        logic [1:0]  ty;
        logic [4:0]  amt;
        logic [31:0] rs;
        logic [31:0] op;
        logic        cin;
        logic [31:0] eb;
        logic        ec;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic imm, input logic rgm, input logic [1:0] ty, input logic [4:0] amt,
                         input logic [31:0] rs, input logic [31:0] op, input logic cin,
                         input logic [31:0] a, input logic [4:0] cntrl);
        Shf_Imm_Mode = imm;
        Shf_Reg_Mode = rgm;
        Shf_Type     = ty;
        Shf_Amt_Imm  = amt;
        Shf_Rs       = rs;
        Shf_Operand  = op;
        Shf_C_In     = cin;
        Shf_A        = a;
        Shf_Cntrl    = cntrl;
    endtask

    task automatic run_vec(input int idx);
        vec_t        v;
        logic [31:0] ea;
        int          lat;
        int          exp_lat;
        v  = vecs[idx];
        ea = 32'hA500_0000 | 32'(idx);
        exp_lat = 1;
`ifdef ARM7_REGSHIFT_EXTRA_CYCLE_EN
        if (v.rgm && !v.imm) exp_lat = 2;
`endif
        drive(v.imm, v.rgm, v.ty, v.amt, v.rs, v.op, v.cin, ea, 5'(idx));
        In_Valid  = 1'b1;
        Out_Ready = 1'b1;
        chk($sformatf("v%0d in_ready", idx), 32'(In_Ready), 32'd1);
        next_cycle();
        // Scramble inputs after accept; results must come from the accepted operation.
        drive(~v.imm, ~v.rgm, ~v.ty, ~v.amt, ~v.rs, ~v.op, ~v.cin, 32'h0, 5'h0);
        In_Valid = 1'b0;
        if (exp_lat == 2) chk($sformatf("v%0d in_ready_wait", idx), 32'(In_Ready), 32'd0);
        lat = 1;
        while (!Out_Valid && lat < 6) begin
            next_cycle();
            lat++;
        end
        chk($sformatf("v%0d latency", idx), 32'(lat), 32'(exp_lat));
        chk($sformatf("v%0d alu_b", idx), Alu_B, v.eb);
        chk($sformatf("v%0d carry", idx), 32'(Shf_Carry), 32'(v.ec));
        chk($sformatf("v%0d alu_a", idx), Alu_A, ea);
        chk($sformatf("v%0d alu_c", idx), 32'(Alu_C), 32'(v.cin));
        chk($sformatf("v%0d alu_cntrl", idx), 32'(Alu_Cntrl), 32'(idx[4:0]));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " out_valid"}, 32'(Out_Valid), 32'd0);
        chk({tag, " alu_a"}, Alu_A, 32'd0);
        chk({tag, " alu_b"}, Alu_B, 32'd0);
        chk({tag, " alu_c"}, 32'(Alu_C), 32'd0);
        chk({tag, " alu_cntrl"}, 32'(Alu_Cntrl), 32'd0);
        chk({tag, " carry"}, 32'(Shf_Carry), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //                 imm   rgm   ty     amt    rs            op            cin   exp_b         exp_c
        vecs.push_back(vec_t'{1'b0, 1'b0, 2'b00, 5'd4,  32'h0,        32'h0000_00F1, 1'b0, 32'h0000_0F10, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 2'b01, 5'd0,  32'h0,        32'h8000_0001, 1'b0, 32'h0000_0000, 1'b1});
        vecs.push_back(vec_t'{1'b0, 1'b0, 2'b11, 5'd0,  32'h0,        32'h0000_0003, 1'b1, 32'h8000_0001, 1'b1});
        vecs.push_back(vec_t'{1'b1, 1'b0, 2'b00, 5'd0,  32'h0,        32'h0000_02FF, 1'b0, 32'hF000_000F, 1'b1});
        vecs.push_back(vec_t'{1'b1, 1'b0, 2'b00, 5'd0,  32'h0,        32'h0000_00FF, 1'b0, 32'h0000_00FF, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 2'b00, 5'd0,  32'h0,        32'h0000_00FF, 1'b1, 32'h0000_00FF, 1'b1});
        vecs.push_back(vec_t'{1'b1, 1'b0, 2'b10, 5'd7,  32'h0,        32'hFFFF_F2FF, 1'b0, 32'hF000_000F, 1'b1});
        vecs.push_back(vec_t'{1'b1, 1'b1, 2'b01, 5'd0,  32'h0000_0040, 32'h0000_0103, 1'b0, 32'hC000_0000, 1'b1});
        vecs.push_back(vec_t'{1'b0, 1'b1, 2'b10, 5'd0,  32'h0000_0040, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1});
        vecs.push_back(vec_t'{1'b0, 1'b1, 2'b00, 5'd0,  32'h0000_0020, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1});
        vecs.push_back(vec_t'{1'b0, 1'b0, 2'b10, 5'd4,  32'h0,        32'h8000_0018, 1'b0, 32'hF800_0001, 1'b1});
        vecs.push_back(vec_t'{1'b0, 1'b0, 2'b10, 5'd0,  32'h0,        32'h7FFF_FFFF, 1'b1, 32'h0000_0000, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 2'b01, 5'd1,  32'h0,        32'h0000_0003, 1'b0, 32'h0000_0001, 1'b1});
        vecs.push_back(vec_t'{1'b0, 1'b0, 2'b11, 5'd8,  32'h0,        32'h1234_5678, 1'b1, 32'h7812_3456, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 2'b00, 5'd31, 32'h0,        32'h0000_0003, 1'b0, 32'h8000_0000, 1'b1});
        vecs.push_back(vec_t'{1'b0, 1'b0, 2'b00, 5'd0,  32'h0,        32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1});
        vecs.push_back(vec_t'{1'b0, 1'b1, 2'b00, 5'd0,  32'h0000_0021, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 2'b01, 5'd0,  32'h0000_0020, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1});
        vecs.push_back(vec_t'{1'b0, 1'b1, 2'b01, 5'd0,  32'h0000_0000, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1});
        vecs.push_back(vec_t'{1'b0, 1'b1, 2'b11, 5'd0,  32'h0000_0020, 32'h8000_0001, 1'b0, 32'h8000_0001, 1'b1});
        vecs.push_back(vec_t'{1'b0, 1'b1, 2'b11, 5'd0,  32'h0000_0024, 32'h0000_0018, 1'b0, 32'h8000_0001, 1'b1});
        vecs.push_back(vec_t'{1'b0, 1'b1, 2'b00, 5'd0,  32'h0000_0104, 32'h0000_0001, 1'b1, 32'h0000_0010, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 2'b01, 5'd0,  32'h0000_0004, 32'h0000_00F8, 1'b0, 32'h0000_000F, 1'b1});
        vecs.push_back(vec_t'{1'b0, 1'b1, 2'b10, 5'd0,  32'h0000_001F, 32'h4000_0000, 1'b0, 32'h0000_0000, 1'b1});

        reset     = 1'b1;
        In_Valid  = 1'b0;
        Out_Ready = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 5'h0);
        @(negedge clk);
        next_cycle();
        chk_zero("reset");
        reset = 1'b0;
        next_cycle();
        chk("reset in_ready", 32'(In_Ready), 32'd1);

        for (int i = 0; i < vecs.size(); i++) run_vec(i);
        next_cycle();
        chk("drain out_valid", 32'(Out_Valid), 32'd0);

        // Backpressure for three cycles, then handshake and accept in the same cycle.
        drive(1'b0, 1'b0, 2'b00, 5'd4, 32'h0, 32'h0000_00F1, 1'b0, 32'h1111_1111, 5'h03);
        In_Valid  = 1'b1;
        Out_Ready = 1'b0;
        next_cycle();
        drive(1'b0, 1'b0, 2'b00, 5'd8, 32'h0, 32'h0100_00AB, 1'b1, 32'h2222_2222, 5'h0C);
        chk("stall out_valid", 32'(Out_Valid), 32'd1);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            chk($sformatf("stall%0d out_valid", k), 32'(Out_Valid), 32'd1);
            chk($sformatf("stall%0d alu_b", k), Alu_B, 32'h0000_0F10);
            chk($sformatf("stall%0d carry", k), 32'(Shf_Carry), 32'd0);
            chk($sformatf("stall%0d alu_a", k), Alu_A, 32'h1111_1111);
            chk($sformatf("stall%0d alu_cntrl", k), 32'(Alu_Cntrl), 32'h03);
            chk($sformatf("stall%0d in_ready", k), 32'(In_Ready), 32'd0);
        end
        Out_Ready = 1'b1;
        #1;
        chk("release in_ready", 32'(In_Ready), 32'd1);
        next_cycle();
        In_Valid = 1'b0;
        chk("nobubble out_valid", 32'(Out_Valid), 32'd1);
        chk("nobubble alu_b", Alu_B, 32'h0000_AB00);
        chk("nobubble carry", 32'(Shf_Carry), 32'd1);
        chk("nobubble alu_a", Alu_A, 32'h2222_2222);
        chk("nobubble alu_c", 32'(Alu_C), 32'd1);
        next_cycle();
        chk("nobubble drain", 32'(Out_Valid), 32'd0);

        // Reset while a register shift is in flight.
        drive(1'b0, 1'b1, 2'b10, 5'd0, 32'h0000_0040, 32'h8000_0000, 1'b1, 32'h1234_5678, 5'h1F);
        In_Valid = 1'b1;
        next_cycle();
        In_Valid = 1'b0;
        reset    = 1'b1;
        next_cycle();
        chk_zero("rst_inflight");
        reset = 1'b0;
        next_cycle();
        chk("rst_inflight in_ready", 32'(In_Ready), 32'd1);
        chk("rst_inflight dropped", 32'(Out_Valid), 32'd0);
        next_cycle();
        chk("rst_inflight dropped2", 32'(Out_Valid), 32'd0);

        // Reset while a result is held under backpressure.
        drive(1'b1, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0000_02FF, 1'b1, 32'hDEAD_BEEF, 5'h15);
        In_Valid  = 1'b1;
        Out_Ready = 1'b0;
        next_cycle();
        In_Valid = 1'b0;
        chk("rst_held out_valid", 32'(Out_Valid), 32'd1);
        chk("rst_held alu_b", Alu_B, 32'hF000_000F);
        reset = 1'b1;
        next_cycle();
        chk_zero("rst_held");
        reset = 1'b0;
        next_cycle();
        chk("rst_held in_ready", 32'(In_Ready), 32'd1);
        chk("rst_held out_valid_after", 32'(Out_Valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
